// File: rtl/cnn_pkg.sv
// Constants shared across the CNN datapath and the flatten-stage state encoding.
package cnn_pkg;

    localparam int unsigned CH       = 32;
    localparam int unsigned POS      = 49;
    localparam int unsigned AW       = 11;
    localparam int unsigned FLAT_LEN = CH * POS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_DONE
    } flat_state_e;

endpackage

// File: rtl/flat_addr_gen.sv
// Channel-major flat address generator: addr = ch*POS + pos, built from a running base.
module flat_addr_gen #(
    parameter int unsigned CH  = cnn_pkg::CH,
    parameter int unsigned POS = cnn_pkg::POS,
    parameter int unsigned AW  = cnn_pkg::AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PW = (POS > 1) ? $clog2(POS) : 1;

    logic [CW-1:0] ch_q, ch_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [AW-1:0] base_q, base_d;

    assign last_o = (ch_q == CW'(CH - 1)) && (pos_q == PW'(POS - 1));
    assign addr_o = base_q + AW'(pos_q);

    // Saturates on the final address so a late advance can never wrap the frame.
    always_comb begin
        ch_d   = ch_q;
        pos_d  = pos_q;
        base_d = base_q;
        if (clr_i) begin
            ch_d   = '0;
            pos_d  = '0;
            base_d = '0;
        end else if (adv_i && !last_o) begin
            if (pos_q == PW'(POS - 1)) begin
                pos_d  = '0;
                ch_d   = ch_q + CW'(1);
                base_d = base_q + AW'(POS);
            end else begin
                pos_d = pos_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_q   <= '0;
            pos_q  <= '0;
            base_q <= '0;
        end else begin
            ch_q   <= ch_d;
            pos_q  <= pos_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/flatten_ctrl.sv
// Flatten-stage sequencer: sequences pooled-beat writes, then drains the buffer channel-major.
module flatten_ctrl #(
    parameter int unsigned CH  = cnn_pkg::CH,
    parameter int unsigned POS = cnn_pkg::POS,
    parameter int unsigned AW  = cnn_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          wr_en,
    output logic [5:0]    wr_pos,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    import cnn_pkg::*;

    localparam int unsigned FLAT = CH * POS;
    localparam int unsigned IW   = $clog2(FLAT + 1);

    flat_state_e   state_q, state_d;
    logic [5:0]    fill_pos_q, fill_pos_d;
    logic [IW-1:0] issued_q, issued_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          addr_last;
    logic          addr_clr;

    assign addr_clr = (state_q != ST_DRAIN);

    flat_addr_gen #(
        .CH  (CH),
        .POS (POS),
        .AW  (AW)
    ) u_addr_gen (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (addr_clr),
        .adv_i  (rd_en),
        .addr_o (rd_addr),
        .last_o (addr_last)
    );

    always_comb begin
        state_d     = state_q;
        fill_pos_d  = fill_pos_q;
        issued_d    = issued_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        wr_en = (state_q == ST_FILL) && in_valid;
        rd_en = (state_q == ST_DRAIN) && (issued_q < IW'(FLAT)) && (!out_valid_q || out_ready);

        // Output register mirrors the one-cycle buffer read: load on read, drop on accept.
        if (rd_en) begin
            out_valid_d = 1'b1;
            out_last_d  = addr_last;
            issued_d    = issued_q + IW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FILL;
                    fill_pos_d = '0;
                    issued_d   = '0;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    if (fill_pos_q == 6'(POS - 1)) begin
                        fill_pos_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        fill_pos_d = fill_pos_q + 6'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                issued_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fill_pos_q  <= '0;
            issued_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_pos_q  <= fill_pos_d;
            issued_q    <= issued_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign wr_pos    = fill_pos_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: doc/flatten_ctrl.md
# flatten_ctrl

Sequencing controller for the flatten stage of the digit-classification CNN. It accepts one frame of 32 channel streams × 49 pooled positions from the last pooling layer and drives the write position of the 1568-entry flatten buffer. It then scans the buffer in channel-major order (address = ch·49 + pos), issuing one read per accepted beat toward the dense layer under a valid/ready handshake. It holds no data; it emits addresses, enables and framing only.

## Interface
- `CH`, 32, channel count
- `POS`, 49, positions per channel (7×7)
- `AW`, 11, buffer address width; must satisfy 2^AW ≥ CH·POS
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (rst=0 resets)
- `start`  in  1  frame start pulse; honoured only in IDLE
- `in_valid`  in  1  one pooled beat (all 32 channels) present this cycle
- `wr_en`  out  1  buffer write strobe
- `wr_pos`  out  6  position 0..POS-1; buffer writes channel k at wr_pos + k·POS
- `rd_en`  out  1  buffer read strobe; buffer output register holds when low
- `rd_addr`  out  AW  flattened read address
- `out_valid`  out  1  buffer output is a valid flattened element
- `out_last`  out  1  qualifies the element at address CH·POS-1
- `out_ready`  in  1  dense layer accepts the element
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: start=1 → FILL; pos counter ← 0.
- FILL: `wr_en = in_valid`, `wr_pos` = pos counter. Pos increments on each in_valid. On the beat with pos = POS-1, go to DRAIN. in_valid outside FILL is ignored.
- DRAIN: addressing uses counters `ch` (0..CH-1), `pos` (0..POS-1) and `base` (= ch·POS, advanced by +POS when pos wraps). `rd_addr = base + pos`; no multiplier.
  - `rd_en = (issued < CH·POS) && (!out_valid || out_ready)`.
  - Counters advance on each rd_en.
  - `out_valid` next = 1 if rd_en; else 0 if out_ready; else hold.
  - `out_last` is registered alongside out_valid; set when the issued address is CH·POS-1.
- Handshake completes when out_valid & out_ready. Completion of the last beat → DONE.
- DONE: `done=1` for one cycle, then IDLE. start during DONE is ignored.
- start while busy is ignored. out_ready is a don't-care when out_valid=0.
- All counters are unsigned. No wrap is permitted past CH·POS-1.

## Timing
- Reset values: state IDLE; all counters 0; wr_en, rd_en, out_valid, out_last, busy, done = 0; wr_pos 0; rd_addr 0.
- Reset asserted mid-frame aborts immediately to IDLE. No done is emitted.
- start at edge t → busy=1 from t+1. The first in_valid can be written at t+1.
- The 49th accepted beat at edge f → DRAIN at f+1 with rd_en=1, rd_addr=0. out_valid=1 at f+2.
- Buffer read latency is fixed at 1 cycle; out_valid tracks rd_en delayed by 1.
- With out_ready held at 1, the frame drains in exactly CH·POS cycles of out_valid. done comes 1 cycle after the last handshake. Busy time after FILL is CH·POS+2 cycles.
- When out_ready=0 with out_valid=1: rd_en=0, and rd_addr, out_valid and out_last hold until acceptance.

## Structure
- Shared package `cnn_pkg`: CH, POS, AW, FLAT_LEN = CH·POS, and the state enum encoding.
- Single module. The optional sub-module `flat_addr_gen` (ch/pos/base counters producing rd_addr and last) is natural and reusable for the dense-layer weight ROM index.
- The buffer memory lives outside this block.

## Test plan
- Reset during DRAIN at address 700 → all outputs at reset values the same cycle; no done. A following start yields a clean frame.
- start, then 49 contiguous in_valid → wr_pos 0..48 on consecutive cycles. rd_addr sequence 0,1,…,1567; out_valid for 1568 cycles; out_last only on 1567; done 1 cycle later.
- in_valid with gaps (every 3rd cycle) → wr_en only on valid cycles. DRAIN entered one cycle after the 49th beat.
- out_ready toggled 1,0,0,1 repeatedly → no duplicated or skipped address. The scoreboard sees exactly 0..1567 in order, and rd_addr is stable during stalls.
- Check the channel boundary → address after 48 is 49 (ch 1, pos 0). Address after 1518 is 1519 (ch 31, pos 0).
- start pulsed during FILL and DRAIN, and in_valid during DRAIN → ignored; frame order and count unchanged.
